muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer implementing MUL (low 32 bits), DIVU and REMU.
- Computes by issuing one ALU operation per cycle on the core's shared 32-bit ALU, using ADD, SUB and SLTU.
- Sits beside the execute stage; ALU access is arbitrated by an external grant.
- Holds its own operand, accumulator, quotient and iteration-count state.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ALU_ADD, 4'b0000, ALU control code for add.
- ALU_SUB, 4'b0001, ALU control code for subtract.
- ALU_SLTU, 4'b0101, ALU control code for unsigned set-less-than.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  2  operation: 00 MUL, 01 DIVU, 10 REMU, 11 reserved.
- req_a  input  32  multiplicand / dividend.
- req_b  input  32  multiplier / divisor.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  32  result.
- alu_req  output  1  sequencer requests the ALU this cycle.
- alu_gnt  input  1  ALU granted this cycle; alu_result is valid for the driven operands.
- alu_control  output  4  ALU operation code.
- alu_src1  output  32  ALU operand 1.
- alu_src2  output  32  ALU operand 2.
- alu_result  input  32  ALU result, combinational from the driven operands.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, resp_valid=0, resp_data=0, alu_req=0, counter=0. Reset mid-operation aborts the operation with no response; the block is in IDLE next cycle.
- States: IDLE, MUL_ADD, DIV_CMP, DIV_SUB, DONE.
- req_ready=1 only in IDLE (combinational). Accept when req_valid & req_ready; latch op, a, b; clear the counter.
- Transitions from IDLE on accept:
  - MUL -> MUL_ADD; acc=0, mcand=a, mplier=b.
  - DIVU/REMU with b==0 -> DONE; result = 32'hFFFFFFFF (DIVU) or a (REMU).
  - DIVU/REMU with b!=0 -> DIV_CMP; rem=0 with 33-bit internal form {rem_msb, rem[31:0]}; q=a.
  - Reserved op -> DONE; result=0.
- alu_req=1 in MUL_ADD, DIV_CMP and DIV_SUB. A state advances only in cycles with alu_gnt=1; otherwise all state holds.
- Outside ALU states: alu_control=ALU_ADD, alu_src1=alu_src2=0.
- MUL_ADD: alu_control=ADD, src1=acc, src2=mcand.
  - On grant: if mplier[0], acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1; counter++.
  - After the 32nd grant -> DONE with result=acc (modulo 2^32).
- DIV_CMP: shifted value s={rem[31:0],q[31]}, s_msb=rem[31]. alu_control=SLTU, src1=s[31:0], src2=b.
  - On grant: latch s into rem, s_msb into rem_msb, q<=q<<1; ge = rem_msb | ~alu_result[0]; -> DIV_SUB.
- DIV_SUB: alu_control=SUB, src1=rem[31:0], src2=b.
  - On grant: if ge, rem<=alu_result, rem_msb<=0, q[0]<=1; counter++.
  - After the 32nd iteration -> DONE; else -> DIV_CMP.
  - The SUB is always issued, so latency is fixed.
- DONE: resp_valid=1, resp_data=result held stable until resp_ready. On resp_valid & resp_ready -> IDLE.
  - A new request is accepted no earlier than the cycle after the handshake (no bypass).
- Latency with alu_gnt held 1, request accepted at cycle T:
  - MUL: resp_valid at T+33.
  - DIVU/REMU: resp_valid at T+65.
  - Divide-by-zero and reserved: resp_valid at T+1.
  - Each withheld grant adds one cycle.
- Counter is 6-bit; iteration counts are compared exactly, so no wrap occurs.

Test Plan:
- MUL a=7, b=6, gnt=1 -> resp_data=42 at T+33; alu_req high for exactly 32 cycles; MUL a=32'hFFFFFFFF, b=2 -> 32'hFFFFFFFE.
- DIVU a=100, b=7 -> 14 at T+65; REMU same operands -> 2; DIVU a=32'hFFFFFFFF, b=32'h80000001 -> 1; REMU same -> 32'h7FFFFFFE (exercises rem_msb).
- DIVU a=5, b=0 -> 32'hFFFFFFFF at T+1; REMU a=5, b=0 -> 5 at T+1; op=11 -> 0 at T+1.
- MUL 3*5 with alu_gnt toggling 1/0 every cycle -> 15 at T+65; alu_src1/src2/control stable across withheld cycles.
- Result ready with resp_ready=0 for 10 cycles -> resp_valid and resp_data held, req_ready=0; after handshake, req_ready=1 next cycle.
- rst asserted in DIV_CMP at iteration 10 -> next cycle IDLE, resp_valid=0, req_ready=1; following MUL 2*3 returns 6 normally.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential MUL / DIVU / REMU unit that borrows the core's shared ALU one operation per cycle.
// Shift-add multiply and restoring divide; every ALU-using state waits for alu_gnt before advancing.
module muldiv_seq #(
  parameter int unsigned XLEN     = 32,
  parameter logic [3:0]  ALU_ADD  = 4'b0000,
  parameter logic [3:0]  ALU_SUB  = 4'b0001,
  parameter logic [3:0]  ALU_SLTU = 4'b0101
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  input  logic [XLEN-1:0] alu_result
);

  localparam logic [1:0] OpMul  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRemu = 2'b10;
  localparam logic [5:0] LastIter = 6'(XLEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMulAdd,
    StDivCmp,
    StDivSub,
    StDone
  } state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] rem_q;
  logic            rem_msb_q;
  logic [XLEN-1:0] q_q;
  logic            lt_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] div_shift;
  logic            div_ge;
  logic [XLEN-1:0] sub_rem;
  logic [XLEN-1:0] sub_q;
  logic [XLEN-1:0] mul_acc;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_data  = result_q;
  assign alu_req    = (state_q == StMulAdd) || (state_q == StDivCmp) || (state_q == StDivSub);

  // Partial remainder shifted left by one with the next dividend bit brought in.
  assign div_shift = {rem_q[XLEN-2:0], q_q[XLEN-1]};
  // A set 33rd bit means the shifted remainder certainly exceeds the divisor.
  assign div_ge    = rem_msb_q | ~lt_q;
  assign sub_rem   = div_ge ? alu_result : rem_q;
  assign sub_q     = {q_q[XLEN-1:1], q_q[0] | div_ge};
  assign mul_acc   = mplier_q[0] ? alu_result : acc_q;

  always_comb begin
    alu_control = ALU_ADD;
    alu_src1    = '0;
    alu_src2    = '0;
    unique case (state_q)
      StMulAdd: begin
        alu_control = ALU_ADD;
        alu_src1    = acc_q;
        alu_src2    = mcand_q;
      end
      StDivCmp: begin
        alu_control = ALU_SLTU;
        alu_src1    = div_shift;
        alu_src2    = b_q;
      end
      StDivSub: begin
        alu_control = ALU_SUB;
        alu_src1    = rem_q;
        alu_src2    = b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      rem_msb_q <= 1'b0;
      q_q       <= '0;
      lt_q      <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q  <= req_op;
            b_q   <= req_b;
            cnt_q <= '0;
            unique case (req_op)
              OpMul: begin
                acc_q    <= '0;
                mcand_q  <= req_a;
                mplier_q <= req_b;
                state_q  <= StMulAdd;
              end
              OpDivu, OpRemu: begin
                if (req_b == '0) begin
                  result_q <= (req_op == OpDivu) ? '1 : req_a;
                  state_q  <= StDone;
                end else begin
                  rem_q     <= '0;
                  rem_msb_q <= 1'b0;
                  q_q       <= req_a;
                  state_q   <= StDivCmp;
                end
              end
              default: begin
                result_q <= '0;
                state_q  <= StDone;
              end
            endcase
          end
        end
        StMulAdd: begin
          if (alu_gnt) begin
            acc_q    <= mul_acc;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 6'd1;
            if (cnt_q == LastIter) begin
              result_q <= mul_acc;
              state_q  <= StDone;
            end
          end
        end
        StDivCmp: begin
          if (alu_gnt) begin
            rem_q     <= div_shift;
            rem_msb_q <= rem_q[XLEN-1];
            q_q       <= q_q << 1;
            lt_q      <= alu_result[0];
            state_q   <= StDivSub;
          end
        end
        StDivSub: begin
          if (alu_gnt) begin
            rem_q <= sub_rem;
            if (div_ge) begin
              rem_msb_q <= 1'b0;
            end
            q_q   <= sub_q;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == LastIter) begin
              result_q <= (op_q == OpDivu) ? sub_q : sub_rem;
              state_q  <= StDone;
            end else begin
              state_q <= StDivCmp;
            end
          end
        end
        StDone: begin
          if (resp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed checks of muldiv_seq against an arithmetic reference model,
// with the shared ALU modelled behaviourally and grant patterns varied per transaction.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        alu_req;
  logic        alu_gnt;
  logic [3:0]  alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_control(alu_control),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  // Shared core ALU.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      4'b0000: alu_result = alu_src1 + alu_src2;
      4'b0001: alu_result = alu_src1 - alu_src2;
      4'b0101: alu_result = {31'd0, alu_src1 < alu_src2};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      2'b00:   return a * b;
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // ALU operations needed with no withheld grants.
  function automatic int ref_iters(input logic [1:0] op, input logic [31:0] b);
    if (op == 2'b00) return 32;
    if ((op == 2'b01 || op == 2'b10) && b != 0) return 64;
    return 0;
  endfunction

  // gmode: 0 grant always, 1 toggle starting withheld, 2 random. rst_at>0 resets in that cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int gmode, input int hold, input int rst_at, input string tag);
    logic [31:0] exp_data;
    logic [31:0] held;
    logic [3:0]  pc;
    logic [31:0] p1, p2;
    int need, n, withheld, areq, unstable, bad_hold;
    bit prev_wh, done;
    exp_data = ref_result(op, a, b);
    need     = ref_iters(op, b);
    @(negedge clk);
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    resp_ready = 1'b0;
    alu_gnt    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    n = 1; withheld = 0; areq = 0; unstable = 0; prev_wh = 0; done = 0;
    pc = '0; p1 = '0; p2 = '0;
    while (n <= 400) begin
      if (rst_at != 0 && n == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        alu_gnt = 1'b1;
        check({tag, ":rst_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ":rst_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, ":rst_alu_req"}, 32'(alu_req), 32'd0);
        return;
      end
      if (resp_valid) begin
        done = 1;
        break;
      end
      if (alu_req) begin
        areq++;
        if (prev_wh && {alu_control, alu_src1, alu_src2} !== {pc, p1, p2}) unstable++;
      end
      case (gmode)
        0:       alu_gnt = 1'b1;
        1:       alu_gnt = (n % 2 == 0);
        default: alu_gnt = 1'($urandom_range(0, 1));
      endcase
      prev_wh = alu_req && !alu_gnt;
      if (prev_wh) begin
        withheld++;
        pc = alu_control; p1 = alu_src1; p2 = alu_src2;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, ":resp_seen"}, 32'(done), 32'd1);
    if (!done) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check({tag, ":latency"}, 32'(n), 32'(need + 1 + withheld));
    check({tag, ":alu_req_cycles"}, 32'(areq), 32'(need + withheld));
    check({tag, ":data"}, resp_data, exp_data);
    check({tag, ":alu_stable"}, 32'(unstable), 32'd0);
    held = resp_data;
    bad_hold = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 1'b0) bad_hold++;
    end
    if (hold > 0) check({tag, ":hold"}, 32'(bad_hold), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ":post_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ":post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    alu_gnt    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:resp_valid", 32'(resp_valid), 32'd0);
    check("reset:resp_data", resp_data, 32'd0);
    check("reset:alu_req", 32'(alu_req), 32'd0);
    check("reset:req_ready", 32'(req_ready), 32'd1);
    check("reset:alu_control", 32'(alu_control), 32'd0);
    check("reset:alu_src1", alu_src1, 32'd0);
    check("reset:alu_src2", alu_src2, 32'd0);
    rst = 1'b0;

    do_op(2'b00, 32'd7, 32'd6, 0, 0, 0, "mul_7x6");
    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "mul_max_x2");
    do_op(2'b01, 32'd100, 32'd7, 0, 0, 0, "divu_100_7");
    do_op(2'b10, 32'd100, 32'd7, 0, 0, 0, "remu_100_7");
    do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 0, "divu_big");
    do_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 0, "remu_big");
    do_op(2'b01, 32'd5, 32'd0, 0, 0, 0, "divu_by0");
    do_op(2'b10, 32'd5, 32'd0, 0, 0, 0, "remu_by0");
    do_op(2'b11, 32'd9, 32'd4, 0, 0, 0, "reserved");
    do_op(2'b00, 32'd3, 32'd5, 1, 0, 0, "mul_toggle");
    do_op(2'b01, 32'd100, 32'd7, 0, 10, 0, "backpressure");
    do_op(2'b01, 32'd1000, 32'd3, 0, 0, 21, "rst_mid");
    do_op(2'b00, 32'd2, 32'd3, 0, 0, 0, "mul_after_rst");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_op(op, a, b, $urandom_range(0, 2), $urandom_range(0, 3), 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
